// File: rtl/hazard3_regfile_1wnr_clr_if.sv
// Register file access bundle: read ports, write port and clear-busy status.
interface hazard3_regfile_1wnr_clr_if #(
  parameter int N_READ = 2,
  parameter int W_ADDR = 5,
  parameter int W_DATA = 32
);
  logic [N_READ-1:0]        ren;
  logic [N_READ*W_ADDR-1:0] raddr;
  logic [N_READ*W_DATA-1:0] rdata;
  logic [W_ADDR-1:0]        waddr;
  logic [W_DATA-1:0]        wdata;
  logic                     wen;
  logic                     clr_busy;

  modport master (output ren, raddr, waddr, wdata, wen, input rdata, clr_busy);
  modport slave  (input ren, raddr, waddr, wdata, wen, output rdata, clr_busy);
endinterface

// File: rtl/hazard3_regfile_1wnr_clr.sv
// 1-write / N-read register file with registered reads, bypass, zero r0 and post-reset clear.
// state | meaning:  S_CLEAR | zeroing mem[cnt_q], ports ignored;  S_RUN | normal read/write
module hazard3_regfile_1wnr_clr #(
  parameter int N_REGS         = 32,
  parameter int W_DATA         = 32,
  parameter int W_ADDR         = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  parameter int N_READ         = 2,
  parameter int ZERO_REG0      = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic clk,
  input  logic rst,
  hazard3_regfile_1wnr_clr_if.slave rf
);
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam state_t S_INIT = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
  localparam logic [W_ADDR-1:0] LAST = W_ADDR'(N_REGS - 1);

  state_t                         state_q, state_d;
  logic [W_ADDR-1:0]              cnt_q, cnt_d;
  logic [N_READ-1:0][W_DATA-1:0]  rdata_q;
  logic [N_READ-1:0][W_DATA-1:0]  rd_val;
  logic [W_ADDR-1:0]              ra [N_READ];
  logic [W_DATA-1:0]              mem [N_REGS];
  logic                           mem_we;
  logic [W_ADDR-1:0]              mem_wa;
  logic [W_DATA-1:0]              mem_wd;
  logic                           wr_ok;

  function automatic logic in_range(input logic [W_ADDR-1:0] a);
    return 32'(a) < 32'(N_REGS);
  endfunction

  assign wr_ok = rf.wen && in_range(rf.waddr) && !(ZERO_REG0 != 0 && rf.waddr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = rf.waddr;
    mem_wd  = rf.wdata;
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN:   mem_we = wr_ok;
      default: state_d = S_INIT;
    endcase
  end

  // Array has no reset so it can map onto block RAM; writes are held off while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    for (int p = 0; p < N_READ; p++) begin
      ra[p]     = rf.raddr[p*W_ADDR +: W_ADDR];
      rd_val[p] = '0;
      if (!in_range(ra[p]) || (ZERO_REG0 != 0 && ra[p] == '0)) rd_val[p] = '0;
      else if (BYPASS != 0 && wr_ok && rf.waddr == ra[p])        rd_val[p] = rf.wdata;
      else                                                        rd_val[p] = mem[ra[p]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == S_RUN) begin
      for (int p = 0; p < N_READ; p++) begin
        if (rf.ren[p]) rdata_q[p] <= rd_val[p];
      end
    end
  end

  assign rf.rdata    = rdata_q;
  assign rf.clr_busy = (state_q == S_CLEAR);
endmodule

// File: tb/tb_hazard3_regfile_1wnr_clr.sv
// Two register file instances (32 regs with bypass; 24 regs without) against a behavioural model.
module tb_hazard3_regfile_1wnr_clr;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ren;
  logic [4:0]  ra0, ra1, waddr;
  logic [31:0] wdata;
  logic        wen;
  int          n_chk = 0;
  int          n_fail = 0;

  hazard3_regfile_1wnr_clr_if #(.N_READ(2), .W_ADDR(5), .W_DATA(32)) ifa ();
  hazard3_regfile_1wnr_clr_if #(.N_READ(2), .W_ADDR(5), .W_DATA(32)) ifb ();

  assign ifa.ren = ren;  assign ifa.raddr = {ra1, ra0};  assign ifa.waddr = waddr;
  assign ifa.wdata = wdata;  assign ifa.wen = wen;
  assign ifb.ren = ren;  assign ifb.raddr = {ra1, ra0};  assign ifb.waddr = waddr;
  assign ifb.wdata = wdata;  assign ifb.wen = wen;

  hazard3_regfile_1wnr_clr #(.N_REGS(32), .W_DATA(32), .N_READ(2), .ZERO_REG0(1), .BYPASS(1),
    .CLEAR_ON_RESET(1)) dut_a (.clk(clk), .rst(rst), .rf(ifa));
  hazard3_regfile_1wnr_clr #(.N_REGS(24), .W_DATA(32), .N_READ(2), .ZERO_REG0(1), .BYPASS(0),
    .CLEAR_ON_RESET(1)) dut_b (.clk(clk), .rst(rst), .rf(ifb));

  always #5 clk = ~clk;

  // Reference model: architectural contents, expected read data, clear cycles remaining.
  int          nregs [2] = '{32, 24};
  bit          byp   [2] = '{1'b1, 1'b0};
  logic [31:0] mm    [2][32];
  logic [31:0] er    [2][2];
  int          clr_left [2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        er[k][0] = '0; er[k][1] = '0; clr_left[k] = nregs[k];
      end else if (clr_left[k] > 0) begin
        mm[k][nregs[k] - clr_left[k]] = '0;
        clr_left[k]--;
      end else begin
        bit wok;
        wok = wen && (int'(waddr) < nregs[k]) && (waddr != 0);
        for (int p = 0; p < 2; p++) begin
          int a;
          a = (p == 0) ? int'(ra0) : int'(ra1);
          if (ren[p]) begin
            if (a >= nregs[k] || a == 0)                  er[k][p] = '0;
            else if (byp[k] && wok && int'(waddr) == a)   er[k][p] = wdata;
            else                                          er[k][p] = mm[k][a];
          end
        end
        if (wok) mm[k][waddr] = wdata;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_rd0", ifa.rdata[31:0],  er[0][0]);
    chk("a_rd1", ifa.rdata[63:32], er[0][1]);
    chk("b_rd0", ifb.rdata[31:0],  er[1][0]);
    chk("b_rd1", ifb.rdata[63:32], er[1][1]);
    chk("a_busy", {31'b0, ifa.clr_busy}, {31'b0, clr_left[0] > 0});
    chk("b_busy", {31'b0, ifb.clr_busy}, {31'b0, clr_left[1] > 0});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    wen = 1'b0; ren = 2'b00;
  endtask

  task automatic randomize_inputs();
    wen = 1'($urandom); ren = 2'($urandom); waddr = 5'($urandom);
    wdata = $urandom; ra0 = 5'($urandom); ra1 = 5'($urandom);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      er[k][0] = '0; er[k][1] = '0; clr_left[k] = nregs[k];
    end
    #1;
    check_all();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_wait();
    int n = 0, na = -1, nb = -1;
    while ((ifa.clr_busy || ifb.clr_busy) && n < 200) begin
      randomize_inputs();
      step();
      n++;
      if (!ifa.clr_busy && na < 0) na = n;
      if (!ifb.clr_busy && nb < 0) nb = n;
    end
    idle();
    chk("busy_len_a", 32'(na), 32'd32);
    chk("busy_len_b", 32'(nb), 32'd24);
  endtask

  initial begin
    rst = 1'b1; idle(); waddr = '0; wdata = '0; ra0 = '0; ra1 = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) mm[k][i] = '0;
      er[k][0] = '0; er[k][1] = '0; clr_left[k] = nregs[k];
    end
    #1;
    check_all();
    step(); step();
    rst = 1'b0;
    clear_wait();

    // Preload every entry, reset, and expect a fully cleared array.
    for (int a = 0; a < 32; a++) begin
      wen = 1'b1; waddr = 5'(a); wdata = 32'hDEADBEEF; step();
    end
    idle();
    pulse_rst();
    clear_wait();
    for (int a = 0; a < 32; a++) begin
      ren = 2'b11; ra0 = 5'(a); ra1 = 5'(31 - a); step();
      chk("clr_rd", ifa.rdata[31:0], 32'h0);
    end
    idle();

    // Plain write then dual-port read of the same address.
    wen = 1'b1; waddr = 5'd5; wdata = 32'h12345678; step();
    wen = 1'b0; ren = 2'b11; ra0 = 5'd5; ra1 = 5'd5; step();
    chk("wr_rd_a0", ifa.rdata[31:0],  32'h12345678);
    chk("wr_rd_a1", ifa.rdata[63:32], 32'h12345678);
    chk("wr_rd_b1", ifb.rdata[63:32], 32'h12345678);

    // Same-cycle write/read: forwarded with bypass, old value without.
    idle(); wen = 1'b1; waddr = 5'd7; wdata = 32'hA; step();
    wdata = 32'hB; ren = 2'b01; ra0 = 5'd7; step();
    chk("byp_a", ifa.rdata[31:0], 32'hB);
    chk("byp_b", ifb.rdata[31:0], 32'hA);
    wen = 1'b0; step();
    chk("byp_after_b", ifb.rdata[31:0], 32'hB);

    // Zero register and out-of-range addresses.
    idle(); wen = 1'b1; waddr = 5'd6; wdata = 32'h666; step();
    waddr = 5'd0; wdata = 32'hFFFF; step();
    waddr = 5'd30; wdata = 32'h3030; step();
    wen = 1'b0; ren = 2'b11; ra0 = 5'd0; ra1 = 5'd30; step();
    chk("zero_a", ifa.rdata[31:0], 32'h0);
    chk("zero_b", ifb.rdata[31:0], 32'h0);
    chk("range_a", ifa.rdata[63:32], 32'h3030);
    chk("range_b", ifb.rdata[63:32], 32'h0);
    ren = 2'b01; ra0 = 5'd6; step();
    chk("alias_b", ifb.rdata[31:0], 32'h666);

    // Port 1 holds while its enable is low, even as the entry is rewritten.
    idle(); wen = 1'b1; waddr = 5'd9; wdata = 32'h55; step();
    wen = 1'b0; ren = 2'b10; ra1 = 5'd9; step();
    chk("hold_pre", ifa.rdata[63:32], 32'h55);
    wen = 1'b1; wdata = 32'h66; ren = 2'b01; ra0 = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold", ifa.rdata[63:32], 32'h55);
    end
    wen = 1'b0; ren = 2'b10; step();
    chk("hold_post", ifa.rdata[63:32], 32'h66);

    for (int i = 0; i < 400; i++) begin
      randomize_inputs(); step();
    end

    // Reset during clear at count 10, then during normal operation.
    idle(); pulse_rst();
    for (int i = 0; i < 10; i++) begin
      randomize_inputs(); step();
    end
    pulse_rst();
    clear_wait();
    for (int i = 0; i < 60; i++) begin
      randomize_inputs(); ren = 2'b11; step();
    end
    pulse_rst();
    clear_wait();
    for (int i = 0; i < 100; i++) begin
      randomize_inputs(); step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
